instr_mem_responder: RTL and testbench

Clocked instruction-memory responder serving the CPU's fetch port: the CPU presents a byte address and a read request, and this block stalls it with a busy-wait signal for a fixed number of cycles before returning the 32-bit instruction word. It also provides a byte-wide program-load port so a bench or loader can fill the array before or between CPU resets. It sits between the CPU fetch stage and the bench/loader. It replaces the behavioural zero-state fetch model.

---
 rtl/instr_mem_responder_if.sv | 22 ++
 rtl/instr_mem_responder.sv | 72 +++++++
 tb/tb_instr_mem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// Fetch and program-load bus between the CPU/loader (master) and the instruction memory (slave).
interface instr_mem_responder_if #(
  parameter int unsigned AW = 10
);
  logic          READ;
  logic [AW-1:0] ADDRESS;
  logic [31:0]   READDATA;
  logic          BUSYWAIT;
  logic          PROG_EN;
  logic [AW-1:0] PROG_ADDR;
  logic [7:0]    PROG_DATA;

  modport master (
    output READ, ADDRESS, PROG_EN, PROG_ADDR, PROG_DATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, ADDRESS, PROG_EN, PROG_ADDR, PROG_DATA,
    output READDATA, BUSYWAIT
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Byte-array instruction memory that stalls each word fetch for LATENCY cycles,
// with a byte-wide load port that is independent of the fetch FSM and of reset.
module instr_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 3
) (
  input logic                  CLK,
  input logic                  RESET,
  instr_mem_responder_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  logic [7:0]       mem [DEPTH];
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    base_q;
  logic [31:0]      rdata_q;
  logic [AW-1:0]    base_c;
  logic             accept_c;

  assign base_c   = bus.ADDRESS & ~AW'(3);
  assign accept_c = (state_q == IDLE) && bus.READ && !RESET;

  // Combinational in IDLE so the CPU's PC update is blocked in the request cycle.
  assign bus.BUSYWAIT = accept_c || ((state_q == BUSY) && !RESET);
  assign bus.READDATA = rdata_q;

  // Load port: contents are deliberately outside reset.
  always_ff @(posedge CLK) begin
    if (bus.PROG_EN) begin
      mem[bus.PROG_ADDR] <= bus.PROG_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.READ) begin
            base_q  <= base_c;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            // Non-blocking read sees pre-write bytes on a same-edge load collision.
            rdata_q <= {mem[base_q + AW'(3)], mem[base_q + AW'(2)],
                        mem[base_q + AW'(1)], mem[base_q]};
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: byte-array model, fetch latency and collision checks.
module tb_instr_mem_responder;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;
  logic [7:0]  mem_m [DEPTH];
  logic [31:0] sb [$];

  instr_mem_responder_if #(.AW(AW)) bus ();

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [AW-1:0] addr);
    logic [AW-1:0] b;
    b = addr & ~AW'(3);
    return {mem_m[b + AW'(3)], mem_m[b + AW'(2)], mem_m[b + AW'(1)], mem_m[b]};
  endfunction

  task automatic prog_byte(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.PROG_EN = 1'b1; bus.PROG_ADDR = a; bus.PROG_DATA = d;
    @(posedge CLK); #1;
    bus.PROG_EN = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic prog_word(input logic [AW-1:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) prog_byte(a + AW'(k), w[8*k +: 8]);
  endtask

  // Single fetch; optionally fires a load-port write on the capture edge.
  task automatic fetch(input string tag, input logic [AW-1:0] addr,
                       input bit coll, input logic [AW-1:0] ca, input logic [7:0] cd);
    int cycles;
    logic [31:0] exp;
    @(negedge CLK);
    bus.READ = 1'b1; bus.ADDRESS = addr;
    #1 chk({tag, "_bw_req"}, 32'(bus.BUSYWAIT), 32'd1);
    sb.push_back(model_word(addr));
    @(posedge CLK); #1;
    bus.READ = 1'b0;
    bus.ADDRESS = addr ^ AW'(8);
    cycles = 0;
    while (bus.BUSYWAIT && cycles < 20) begin
      if (coll && cycles == LATENCY - 1) begin
        bus.PROG_EN = 1'b1; bus.PROG_ADDR = ca; bus.PROG_DATA = cd;
      end
      @(posedge CLK); #1;
      if (bus.PROG_EN) begin
        bus.PROG_EN = 1'b0;
        mem_m[ca] = cd;
      end
      cycles++;
    end
    chk({tag, "_lat"}, 32'(cycles), 32'(LATENCY));
    exp = sb.pop_front();
    chk({tag, "_data"}, bus.READDATA, exp);
    @(posedge CLK); #1;
    chk({tag, "_idle_bw"}, 32'(bus.BUSYWAIT), 32'd0);
  endtask

  initial begin
    int t, last_t, k;
    logic [AW-1:0] ra;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    RESET = 1'b1;
    bus.READ = 1'b0; bus.ADDRESS = '0;
    bus.PROG_EN = 1'b0; bus.PROG_ADDR = '0; bus.PROG_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdata", bus.READDATA, 32'h0);
    chk("rst_bw", 32'(bus.BUSYWAIT), 32'd0);

    // Loads during reset must land; clear the words read later.
    prog_word(AW'(0), 32'h00000002);
    prog_word(AW'(4), 32'h00010008);
    prog_word(AW'(8), 32'hCAFEF00D);
    prog_word(AW'(12), 32'h0);
    prog_word(AW'(1020), 32'h0);
    @(negedge CLK); RESET = 1'b0;

    fetch("basic", AW'(0), 1'b0, '0, '0);
    fetch("misalign", AW'(6), 1'b0, '0, '0);
    chk("misalign_lit", model_word(AW'(6)), 32'h00010008);

    // Back-to-back with READ held high.
    @(negedge CLK);
    bus.READ = 1'b1; bus.ADDRESS = AW'(0);
    sb.push_back(model_word(AW'(0)));
    sb.push_back(model_word(AW'(4)));
    sb.push_back(model_word(AW'(8)));
    t = 0; last_t = -1; k = 0;
    while (k < 3 && t < 40) begin
      @(posedge CLK); #1;
      t++;
      if (!bus.BUSYWAIT) begin
        chk("b2b_data", bus.READDATA, sb.pop_front());
        if (last_t >= 0) chk("b2b_gap", 32'(t - last_t), 32'(LATENCY + 2));
        last_t = t;
        k++;
        bus.ADDRESS = AW'(4 * k);
      end
    end
    chk("b2b_count", 32'(k), 32'd3);
    bus.READ = 1'b0;
    sb.delete();
    repeat (2) @(posedge CLK);
    #1;

    // Reset one cycle after acceptance.
    @(negedge CLK);
    bus.READ = 1'b1; bus.ADDRESS = AW'(4);
    @(posedge CLK); #1;
    bus.READ = 1'b0;
    RESET = 1'b1;
    #1 chk("rstmid_bw_comb", 32'(bus.BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    chk("rstmid_bw", 32'(bus.BUSYWAIT), 32'd0);
    chk("rstmid_rdata", bus.READDATA, 32'h0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("rstmid_idle", 32'(bus.BUSYWAIT), 32'd0);
    fetch("after_rst", AW'(0), 1'b0, '0, '0);
    chk("after_rst_lit", bus.READDATA, 32'h00000002);

    // Same-edge write collision: old byte now, new byte next time.
    fetch("coll", AW'(0), 1'b1, AW'(1), 8'hFF);
    chk("coll_lit", bus.READDATA, 32'h00000002);
    fetch("coll_next", AW'(0), 1'b0, '0, '0);
    chk("coll_next_lit", bus.READDATA, 32'h0000FF02);

    // Top of the array.
    prog_byte(AW'(1023), 8'hA5);
    prog_byte(AW'(1020), 8'h11);
    fetch("top", AW'(1022), 1'b0, '0, '0);
    chk("top_msb", 32'(bus.READDATA[31:24]), 32'h000000A5);

    // Random words.
    for (int i = 0; i < 4; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      prog_word(ra & ~AW'(3), $urandom);
      fetch("rand", ra, 1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
